// File: rtl/vid_seq_ctrl_if.sv
// Bus interface for vid_seq_ctrl.
// It carries the instruction handshake, the per-beat request bus and the status outputs.
// master: issue-stage side (drives the instruction and stall).
// slave : sequencer side.
interface vid_seq_ctrl_if #(
  parameter int REQ_BYTE_EN_WIDTH = 8,
  parameter int REQ_ADDR_WIDTH    = 32,
  parameter int VL_WIDTH          = 12
);

  // instruction handshake
  logic                         in_valid;
  logic                         in_ready;
  logic [REQ_ADDR_WIDTH-1:0]    in_addr;
  logic [2:0]                   in_sew;
  logic [VL_WIDTH-1:0]          in_vl;

  // downstream back-pressure
  logic                         stall;

  // beat request
  logic                         out_valid;
  logic [REQ_ADDR_WIDTH-1:0]    out_addr;
  logic [VL_WIDTH-1:0]          out_start_idx;
  logic [2:0]                   out_sew;
  logic [REQ_BYTE_EN_WIDTH-1:0] out_byte_en;

  // status
  logic                         busy;
  logic                         done;

  modport master (
    output in_valid, in_addr, in_sew, in_vl, stall,
    input  in_ready, out_valid, out_addr, out_start_idx, out_sew, out_byte_en,
           busy, done
  );

  modport slave (
    input  in_valid, in_addr, in_sew, in_vl, stall,
    output in_ready, out_valid, out_addr, out_start_idx, out_sew, out_byte_en,
           busy, done
  );

endinterface

// File: rtl/vid_seq_ctrl.sv
// vid_seq_ctrl: sequencer for the vector index-generate (vid.v) datapath.
// It accepts one instruction and splits it into registered per-beat requests.
// It then waits out the datapath latency and pulses done.
// Optional macro VID_TAIL_MASK_EN: when defined, the final beat's byte
// enables cover only the active elements; otherwise every beat is all ones.
module vid_seq_ctrl #(
  parameter int REQ_BYTE_EN_WIDTH = 8,
  parameter int REQ_ADDR_WIDTH    = 32,
  parameter int VL_WIDTH          = 12,
  parameter int PIPE_LATENCY      = 6
) (
  input  logic           clk,
  input  logic           rst,
  vid_seq_ctrl_if.slave  bus
);

  localparam int EW = VL_WIDTH + 1;  // element counter width (no wrap near 2^VL_WIDTH)
  localparam int CW = VL_WIDTH + 2;  // compare width for elem_cnt + EPB
  localparam int DW = (PIPE_LATENCY > 0) ? $clog2(PIPE_LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                       state, state_n;

  // latched instruction and running counters
  logic [REQ_ADDR_WIDTH-1:0]    cur_addr, cur_addr_n;
  logic [1:0]                   sew_q, sew_n;
  logic [VL_WIDTH-1:0]          vl_q, vl_n;
  logic [EW-1:0]                elem_cnt, elem_cnt_n;
  logic [DW-1:0]                drain_cnt, drain_cnt_n;

  // registered beat outputs
  logic                         ov_q, ov_n;
  logic [REQ_ADDR_WIDTH-1:0]    oaddr_q, oaddr_n;
  logic [VL_WIDTH-1:0]          ostart_q, ostart_n;
  logic [2:0]                   osew_q, osew_n;
  logic [REQ_BYTE_EN_WIDTH-1:0] obe_q, obe_n;

  // derived per-beat values
  logic [1:0]                   in_sew_clamped;
  logic [EW-1:0]                epb;
  logic [CW-1:0]                elem_next_wide;
  logic                         last_beat;
  logic [REQ_BYTE_EN_WIDTH-1:0] final_be;

  // SEW codes 4..7 behave as 64-bit elements
  always_comb begin
    in_sew_clamped = bus.in_sew[2] ? 2'd3 : bus.in_sew[1:0];
  end

  // elements per beat and last-beat detection, shifts and adds only
  always_comb begin
    epb            = EW'(REQ_BYTE_EN_WIDTH >> sew_q);
    elem_next_wide = CW'(elem_cnt) + CW'(epb);
    last_beat      = (elem_next_wide >= CW'(vl_q));
  end

`ifdef VID_TAIL_MASK_EN
  logic [EW-1:0]       rem_elems;
  logic [VL_WIDTH+3:0] rem_bytes;

  // final-beat byte enables cover only the remaining active elements
  always_comb begin
    rem_elems = EW'(vl_q) - elem_cnt;
    rem_bytes = (VL_WIDTH + 4)'(rem_elems) << sew_q;
    final_be  = '0;
    for (int unsigned i = 0; i < REQ_BYTE_EN_WIDTH; i++) begin
      final_be[i] = (rem_bytes > (VL_WIDTH + 4)'(i));
    end
  end
`else
  // tail masking is left to the writeback mask logic
  always_comb begin
    final_be = '1;
  end
`endif

  // state register and all sequential state, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      sew_q     <= '0;
      vl_q      <= '0;
      elem_cnt  <= '0;
      drain_cnt <= '0;
      ov_q      <= 1'b0;
      oaddr_q   <= '0;
      ostart_q  <= '0;
      osew_q    <= '0;
      obe_q     <= '0;
    end else begin
      state     <= state_n;
      cur_addr  <= cur_addr_n;
      sew_q     <= sew_n;
      vl_q      <= vl_n;
      elem_cnt  <= elem_cnt_n;
      drain_cnt <= drain_cnt_n;
      ov_q      <= ov_n;
      oaddr_q   <= oaddr_n;
      ostart_q  <= ostart_n;
      osew_q    <= osew_n;
      obe_q     <= obe_n;
    end
  end

  // next-state, counter updates and the beat decided this cycle
  always_comb begin
    state_n     = state;
    cur_addr_n  = cur_addr;
    sew_n       = sew_q;
    vl_n        = vl_q;
    elem_cnt_n  = elem_cnt;
    drain_cnt_n = drain_cnt;
    ov_n        = 1'b0;
    oaddr_n     = oaddr_q;
    ostart_n    = ostart_q;
    osew_n      = osew_q;
    obe_n       = '0;

    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          cur_addr_n = bus.in_addr;
          sew_n      = in_sew_clamped;
          vl_n       = bus.in_vl;
          elem_cnt_n = '0;
          state_n    = (bus.in_vl == '0) ? S_DONE : S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!bus.stall) begin
          ov_n       = 1'b1;
          oaddr_n    = cur_addr;
          ostart_n   = elem_cnt[VL_WIDTH-1:0];
          osew_n     = {1'b0, sew_q};
          obe_n      = last_beat ? final_be : '1;
          cur_addr_n = cur_addr + 1'b1;
          elem_cnt_n = elem_next_wide[EW-1:0];
          if (last_beat) begin
            state_n     = S_DRAIN;
            drain_cnt_n = '0;
          end
        end
      end

      // The first DRAIN cycle is the last beat's out_valid cycle. Holding
      // DRAIN until the count reaches PIPE_LATENCY places DONE exactly
      // PIPE_LATENCY+1 cycles after that beat.
      S_DRAIN: begin
        if (drain_cnt == DW'(PIPE_LATENCY)) begin
          state_n = S_DONE;
        end else begin
          drain_cnt_n = drain_cnt + 1'b1;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // status and beat outputs come straight from registers
  always_comb begin
    bus.in_ready      = (state == S_IDLE);
    bus.busy          = (state != S_IDLE);
    bus.done          = (state == S_DONE);
    bus.out_valid     = ov_q;
    bus.out_addr      = oaddr_q;
    bus.out_start_idx = ostart_q;
    bus.out_sew       = osew_q;
    bus.out_byte_en   = obe_q;
  end

endmodule

// File: tb/tb_vid_seq_ctrl.sv
// Self-checking testbench for vid_seq_ctrl.
// It runs directed and random instructions against an arithmetic model of the beat list and timing.
module tb_vid_seq_ctrl;

  localparam int W   = 8;
  localparam int AW  = 32;
  localparam int VLW = 12;
  localparam int PL  = 6;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vid_seq_ctrl_if #(
    .REQ_BYTE_EN_WIDTH(W),
    .REQ_ADDR_WIDTH(AW),
    .VL_WIDTH(VLW)
  ) bus ();

  vid_seq_ctrl #(
    .REQ_BYTE_EN_WIDTH(W),
    .REQ_ADDR_WIDTH(AW),
    .VL_WIDTH(VLW),
    .PIPE_LATENCY(PL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected byte enables of beat k of an instruction
  function automatic logic [W-1:0] exp_be(input int unsigned sew, input int unsigned vl,
                                          input int unsigned start, input bit last);
    int unsigned nbytes;
    logic [W-1:0] ones;
    ones = '1;
`ifdef VID_TAIL_MASK_EN
    if (last) begin
      nbytes = (vl - start) * (1 << sew);
      if (nbytes >= W) return ones;
      return W'((1 << nbytes) - 1);
    end
`else
    nbytes = last ? 1 : 0;
    if (nbytes > W) return '0;
`endif
    return ones;
  endfunction

  // Issue one instruction and check every cycle until done.
  // stall_pct: random stall probability. stall_mask: forced stall in cycle t (t<32).
  // abort_at: cycle at which rst is pulsed instead of letting the op complete (0 = never).
  task automatic run_op(input logic [AW-1:0] addr, input logic [2:0] sew_raw,
                        input int unsigned vl, input int unsigned stall_pct,
                        input logic [31:0] stall_mask, input int unsigned abort_at);
    int unsigned sew, epb, nb, issued, pk;
    int          done_at;
    bit          pend, st, finished, exp_busy;
    logic [AW-1:0] ea;
    sew = (sew_raw > 3) ? 3 : int'(sew_raw);
    epb = W >> sew;
    nb  = (vl + epb - 1) / epb;
    check("idle_ready", bus.in_ready, 1);
    check("idle_done", bus.done, 0);
    bus.in_valid = 1'b1;
    bus.in_addr  = addr;
    bus.in_sew   = sew_raw;
    bus.in_vl    = VLW'(vl);
    bus.stall    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_addr  = AW'($urandom);
    bus.in_vl    = VLW'($urandom);
    issued   = 0;
    pend     = 1'b0;
    pk       = 0;
    done_at  = (vl == 0) ? 1 : -1;
    finished = 1'b0;
    for (int t = 1; t < 40000; t++) begin
      if (abort_at != 0 && t == int'(abort_at)) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", bus.out_valid, 0);
        check("abort_ready", bus.in_ready, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_be", bus.out_byte_en, 0);
        for (int j = 0; j < PL + 4; j++) begin
          check("abort_no_done", bus.done, 0);
          @(negedge clk);
        end
        bus.stall = 1'b0;
        return;
      end
      exp_busy = (done_at < 0) || (t <= done_at);
      check("valid", bus.out_valid, pend);
      check("done", bus.done, (t == done_at));
      check("busy", bus.busy, exp_busy);
      check("ready", bus.in_ready, !exp_busy);
      if (pend) begin
        ea = addr + AW'(pk);
        check("addr", bus.out_addr, ea);
        check("start_idx", bus.out_start_idx, pk * epb);
        check("sew", bus.out_sew, sew);
        check("byte_en", bus.out_byte_en, exp_be(sew, vl, pk * epb, (pk == nb - 1)));
      end else begin
        check("byte_en_idle", bus.out_byte_en, 0);
      end
      if (t == done_at) begin
        finished = 1'b1;
        break;
      end
      st = ($urandom_range(99) < stall_pct) || (t < 32 && stall_mask[t]);
      bus.stall = st;
      pend = 1'b0;
      if (issued < nb && !st) begin
        pend = 1'b1;
        pk = issued;
        issued++;
        if (issued == nb) done_at = t + 1 + PL + 1;
      end
      @(negedge clk);
    end
    if (!finished) check("timeout", 0, 1);
    bus.stall = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_sew   = '0;
    bus.in_vl    = '0;
    bus.stall    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", bus.in_ready, 1);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_be", bus.out_byte_en, 0);
    check("rst_addr", bus.out_addr, 0);
    check("rst_start", bus.out_start_idx, 0);
    check("rst_sew", bus.out_sew, 0);

    run_op(32'h100, 3'd0, 20, 0, 32'h0, 0);
    run_op(32'h200, 3'd3, 3, 0, 32'h0, 0);
    run_op(32'h200, 3'd7, 3, 0, 32'h0, 0);
    run_op(32'h300, 3'd1, 0, 0, 32'h0, 0);
    run_op(32'h400, 3'd2, 8, 0, 32'h18, 0);
    run_op(32'h500, 3'd0, 64, 0, 32'h0, 5);
    run_op(32'h600, 3'd0, 64, 0, 32'h0, 0);
    run_op(32'h700, 3'd1, 5, 0, 32'h0, 0);
    run_op(32'h710, 3'd1, 5, 0, 32'h0, 0);
    run_op(32'hFFFF_FFFE, 3'd0, 4095, 20, 32'h0, 0);
    run_op(32'h800, 3'd3, 4095, 0, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      logic [2:0]    s;
      int unsigned   v;
      a = AW'($urandom);
      s = 3'($urandom_range(7));
      v = ($urandom_range(9) == 0) ? $urandom_range(4095) : $urandom_range(40);
      run_op(a, s, v, $urandom_range(50), 32'h0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vid_seq_ctrl.md
Name: vid_seq_ctrl

Overview:
- Sequencer for the vector index-generate (vid.v) datapath.
- Accepts one vid instruction (destination base address, SEW, vl) over a valid/ready handshake and breaks it into per-beat requests: address, element start index, SEW, byte enables.
- Issues one beat per cycle unless stalled, then waits for the fixed datapath latency before pulsing done to the issue stage.

Parameters:
- REQ_BYTE_EN_WIDTH, 8, bytes per beat; power of two, ≥8.
- REQ_ADDR_WIDTH, 32, beat address width; address counts beats (+1 per beat).
- VL_WIDTH, 12, width of vl and of element start index.
- PIPE_LATENCY, 6, cycles from a beat entering the datapath to its result leaving it.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  instruction valid
- in_ready  out  1  controller idle, can accept
- in_addr  in  REQ_ADDR_WIDTH  destination base beat address
- in_sew  in  3  element width code 0..3 = 8/16/32/64 bit; values 4..7 are treated as 3
- in_vl  in  VL_WIDTH  element count
- stall  in  1  downstream write port busy; hold issue
- out_valid  out  1  beat request valid
- out_addr  out  REQ_ADDR_WIDTH  beat address
- out_start_idx  out  12  index of first element in beat
- out_sew  out  3  latched SEW
- out_byte_en  out  REQ_BYTE_EN_WIDTH  byte enables of beat
- busy  out  1  instruction in flight
- done  out  1  one-cycle pulse, instruction complete

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- Reset values: all outputs 0 except in_ready=1; state IDLE.
- Elements per beat: EPB = REQ_BYTE_EN_WIDTH >> sew. Beats = ceil(vl/EPB), computed with shifts only, no divider.
- Accept: in_valid && in_ready. Latch addr, sew, vl; clear element counter.
- IDLE:
  - Accept with vl≠0 → ISSUE.
  - Accept with vl=0 → DONE. No beats are issued; done pulses the next cycle.
- ISSUE:
  - Each cycle with !stall: out_valid=1, out_addr=base+beat_cnt, out_start_idx=elem_cnt, out_sew=latched sew.
  - Then beat_cnt+1 and elem_cnt+EPB.
  - Outputs are registered; a beat appears the cycle after it is decided.
  - stall=1: out_valid=0, counters hold, no beat lost or duplicated.
  - After the last beat (elem_cnt+EPB ≥ vl) → DRAIN.
- DRAIN: counts PIPE_LATENCY cycles after the last beat's out_valid cycle, then → DONE. stall is ignored in DRAIN.
- DONE: done=1 for exactly one cycle → IDLE.
- in_ready: 1 only in IDLE. A new instruction can be accepted the cycle after done. There is no overlap of instructions.
- busy: 1 in ISSUE, DRAIN and DONE.
- out_byte_en:
  - All ones on non-final beats.
  - On the final beat, set per the VID_TAIL_MASK_EN option below.
  - 0 when out_valid=0.
- Overflow: elem_cnt uses VL_WIDTH+1 bits internally so vl near 2^VL_WIDTH does not wrap. out_addr wraps modulo 2^REQ_ADDR_WIDTH.
- Reset mid-operation: abort immediately. No done pulse, counters cleared, in_ready=1 next cycle.

Optional Feature:
- Macro VID_TAIL_MASK_EN.
- Defined: on the final beat, out_byte_en covers only active elements. Enable bytes [0, (vl − start_idx)·(1<<sew)); bytes above are 0. A full final beat gives all ones.
- Undefined: out_byte_en is all ones on every valid beat; tail handling is left to the writeback mask logic.

Test Plan (REQ_BYTE_EN_WIDTH=8, PIPE_LATENCY=6):
- sew=0, vl=20, addr=0x100, no stall → beats on 3 consecutive cycles, addr 0x100/0x101/0x102, start_idx 0/8/16. Last byte_en 0x0F with VID_TAIL_MASK_EN, else 0xFF. done 7 cycles after last beat, incl. DONE cycle.
- sew=3, vl=3 → 3 beats, start_idx 0,1,2, byte_en 0xFF each; sew=7 gives identical results.
- vl=0 → no out_valid; done pulses 1 cycle after accept; in_ready back the following cycle.
- sew=2, vl=8, stall high for 2 cycles after the 2nd beat → 4 beats total, start_idx 0,2,4,6, gap of 2 cycles, no duplicates.
- rst asserted during ISSUE of a vl=64, sew=0 op → out_valid=0 and in_ready=1 the cycle after; no done. New op afterwards starts at start_idx 0.
- sew=1, vl=5 with VID_TAIL_MASK_EN → beats start_idx 0,4; final byte_en 0x03. Back-to-back second instruction accepted only after done.
